// File: rtl/output_frame_packer_pkg.sv
// output_frame_packer_pkg: state encodings, frame sizing constants and word-order helper
package output_frame_packer_pkg;
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HDR  = 4'd1,
    S_T2   = 4'd2,
    S_T1   = 4'd3,
    S_T0   = 4'd4,
    S_DAT  = 4'd5
  } state_e;
  typedef logic [2:0] word_idx_t;
  localparam logic [3:0] HDR_MARK_DEF = 4'hA;
  localparam int FRAME_WORDS_TS = 5;
  localparam int FRAME_WORDS_NO_TS = 2;
  function automatic state_e word_state(input word_idx_t i, input bit time_en);
    if (!time_en) return i == 3'd0 ? S_HDR : S_DAT;
    return i == 3'd0 ? S_HDR : i == 3'd1 ? S_T2 : i == 3'd2 ? S_T1 : i == 3'd3 ? S_T0 : S_DAT;
  endfunction
endpackage

// File: rtl/output_frame_packer.sv
// output_frame_packer: captures one result per request and writes it to the output FIFO as a multi-word frame
module output_frame_packer
  import output_frame_packer_pkg::*;
#(
  parameter logic [3:0] HDR_MARK = HDR_MARK_DEF,
  parameter bit TIME_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [3:0]  tag_i,
  input  logic [13:0] adc_data_i,
  input  logic [47:0] time_stamp_i,
  output logic        rdy_o,
  input  logic        fifo_full_i,
  output logic        wr_en_o,
  output logic [15:0] dout_o,
  output logic [15:0] frame_count_o,
  output logic [15:0] drop_count_o,
  output logic [3:0]  state_o
);
  localparam word_idx_t LAST_IDX = word_idx_t'((TIME_EN ? FRAME_WORDS_TS : FRAME_WORDS_NO_TS) - 1);
  state_e state_q, state_d;
  word_idx_t idx_q, idx_d, idx_n;
  logic [3:0] tag_q;
  logic [13:0] adc_q;
  logic [47:0] time_q;
  logic [7:0] seq_q;
  logic [15:0] frame_q, drop_q;
  logic accept, drop, wr, done;
  assign rdy_o = state_q == S_IDLE;
  assign accept = req_i && rdy_o;
  assign drop = req_i && !rdy_o;
  // Writes are suppressed during reset so an aborted frame emits nothing more.
  assign wr = rst_ni && !rdy_o && !fifo_full_i;
  assign done = wr && idx_q == LAST_IDX;
  assign idx_n = idx_q + 3'd1;
  assign wr_en_o = wr;
  assign state_o = state_q;
  assign frame_count_o = frame_q;
  assign drop_count_o = drop_q;
  assign dout_o = state_q == S_HDR ? {HDR_MARK, tag_q, seq_q} :
                  state_q == S_T2  ? time_q[47:32] :
                  state_q == S_T1  ? time_q[31:16] :
                  state_q == S_T0  ? time_q[15:0] :
                  state_q == S_DAT ? {2'b00, adc_q} : 16'h0000;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (accept) begin
      state_d = S_HDR;
      idx_d = '0;
    end else if (wr) begin
      idx_d = idx_n;
      state_d = done ? S_IDLE : word_state(idx_n, TIME_EN);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      tag_q <= '0;
      adc_q <= '0;
      time_q <= '0;
      seq_q <= '0;
      frame_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (accept) begin
        tag_q <= tag_i;
        adc_q <= adc_data_i;
        time_q <= time_stamp_i;
      end
      if (done) begin
        seq_q <= seq_q + 8'd1;
        frame_q <= frame_q + 16'd1;
      end
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
endmodule

// File: doc/output_frame_packer.md
OUTPUT_FRAME_PACKER -- requirements
Module: output_frame_packer

Interface
REQ-001 Parameter HDR_MARK, default 4'hA: marker nibble in bits [15:12] of every frame header word.
REQ-002 Parameter TIME_EN, default 1: when 1, frames carry the 48-bit timestamp; when 0, timestamp words are omitted.
REQ-003 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  single-cycle request; samples tag, adc_data and time_stamp.
REQ-006 tag  input  4  device id of the result source (dev_bus value).
REQ-007 adc_data  input  14  ADC conversion result.
REQ-008 time_stamp  input  48  clock-interface timestamp captured with the result.
REQ-009 rdy  output  1  high when a req will be accepted on this cycle.
REQ-010 fifo_full  input  1  output FIFO full; no write is issued while high.
REQ-011 wr_en  output  1  one-cycle write strobe to the output FIFO.
REQ-012 dout  output  16  FIFO write data, valid when wr_en is high.
REQ-013 frame_count  output  16  frames fully written since reset; wraps at 16 bits.
REQ-014 drop_count  output  16  requests rejected since reset; saturates at 16'hFFFF.
REQ-015 state  output  4  current FSM state encoding, for status readback.

Function
REQ-016 FSM states and encodings: IDLE=0, HDR=1, T2=2, T1=3, T0=4, DAT=5.
REQ-017 rdy shall equal (state==IDLE).
REQ-018 When req is high and rdy is high, the block shall register tag, adc_data and time_stamp, and shall move IDLE->HDR.
REQ-019 When req is high and rdy is low, the request shall be discarded, state shall be unchanged, and drop_count shall increment unless it is at 16'hFFFF.
REQ-020 Header word: dout = {HDR_MARK, tag_r, seq[7:0]}, where seq is an 8-bit frame sequence that wraps 255->0.
REQ-021 Words T2/T1/T0 carry time_r[47:32], time_r[31:16] and time_r[15:0] respectively.
REQ-022 Word DAT carries {2'b00, adc_r}.
REQ-023 In any non-IDLE state, fifo_full==0 shall cause wr_en=1 with that state's word, then advance to the next state in the order HDR->T2->T1->T0->DAT->IDLE.
REQ-024 With TIME_EN=0, the sequence shall be HDR->DAT->IDLE.
REQ-025 In any non-IDLE state, fifo_full==1 shall cause wr_en=0, hold the state, and leave dout unchanged; the stall may last any number of cycles.
REQ-026 The header wr_en shall occur no earlier than 1 cycle after the accepting req; an unstalled frame shall take 5 consecutive write cycles (2 with TIME_EN=0).
REQ-027 On the DAT write, seq and frame_count shall both increment.
REQ-028 rdy shall rise in the cycle after the DAT write, so back-to-back frames are separated by exactly 1 IDLE cycle.
REQ-029 wr_en shall never be high in IDLE.
REQ-030 Captured data shall not change while a frame is in flight.

Reset
REQ-031 When rst_n==0 at a clock edge, the block shall set state=IDLE, wr_en=0, dout=0, seq=0, frame_count=0, drop_count=0, and clear the captured registers.
REQ-032 A reset asserted mid-frame shall abort the frame with no further writes and no count increments.
REQ-033 A req in the same cycle as rst_n==0 shall be ignored.
REQ-034 After rst_n returns high, rdy shall be high on the next cycle.

Structure
REQ-035 A shared package shall hold the state encodings, HDR_MARK default, frame word count constants (5 and 2), and a frame word index type.
REQ-036 The block shall be a single module with no sub-modules.
REQ-037 The block shall instantiate no FIFO; it is placed between logic_control result output and fifo_data_out write port.

Verification
REQ-038 Scenario: rst_n low then high; req with tag=1, adc=14'h1ABC, time=48'h0000_1234_5678, fifo_full=0 -> 5 writes on consecutive cycles: A100, 0000, 1234, 5678, 1ABC; frame_count=1.
REQ-039 Scenario: second identical req -> header A101; 256 frames -> header seq returns to 00.
REQ-040 Scenario: fifo_full held high for 3 cycles after the second write -> wr_en low for 3 cycles, no word lost or duplicated, same 5-word content.
REQ-041 Scenario: req issued during HDR -> dropped, drop_count=1, frame content unaffected.
REQ-042 Scenario: rst_n low during T1 -> no further wr_en, frame_count=0, rdy=1 after release.
REQ-043 Scenario: TIME_EN=0, tag=4, adc=14'h0003 -> 2 writes: A400, 0003.
